// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared sample types and frame constants for the I2S transmit path
package i2s_pkg;
   localparam int SAMPLE_W    = 16;
   localparam int SCLK_PER_CH = 16;
   localparam int MCLK_RATIO  = 256;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t l;
      sample_t r;
   } stereo_t;
endpackage

// File: rtl/i2s_edge_det.sv
// rtl/i2s_edge_det.sv - registers a level and flags its rising and falling edges
module i2s_edge_det (
   input  logic clk_i2s,
   input  logic reset_n,
   input  logic level,
   output logic level_d,
   output logic rise,
   output logic fall
);
   import i2s_pkg::*;

   always_ff @(posedge clk_i2s) begin
      if (!reset_n) begin
         level_d <= 1'b0;
      end else begin
         level_d <= level;
      end
   end

   assign rise = ~level_d & level;
   assign fall = level_d & ~level;
endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - buffers one stereo pair and shifts it out in I2S (Philips) format
module i2s_tx_serializer #(
   parameter int SAMPLE_W       = 16,
   parameter int UNDERRUN_CNT_W = 16
) (
   input  logic                      clk_i2s,
   input  logic                      reset_n,
   input  logic                      i2s_sclk,
   input  logic                      i2s_lrclk,
   input  logic [SAMPLE_W-1:0]       s_data_l,
   input  logic [SAMPLE_W-1:0]       s_data_r,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic                      tx_data,
   output logic                      underrun,
   output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);
   import i2s_pkg::*;

   stereo_t hold_q;
   stereo_t active_q;
   logic    hold_full;
   sample_t sr_q;

   logic sclk_d, sclk_rise, sclk_fall;
   logic lrclk_d, lrclk_rise, lrclk_fall;
   logic left_start, right_start, accept;
   logic unused_edges;

   i2s_edge_det u_sclk_det (
      .clk_i2s (clk_i2s),
      .reset_n (reset_n),
      .level   (i2s_sclk),
      .level_d (sclk_d),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   i2s_edge_det u_lrclk_det (
      .clk_i2s (clk_i2s),
      .reset_n (reset_n),
      .level   (i2s_lrclk),
      .level_d (lrclk_d),
      .rise    (lrclk_rise),
      .fall    (lrclk_fall)
   );

   assign unused_edges = sclk_d ^ sclk_rise ^ lrclk_d;

   // lrclk only counts when it moves together with an sclk fall
   assign left_start  = sclk_fall & lrclk_fall;
   assign right_start = sclk_fall & lrclk_rise;
   assign s_ready     = ~hold_full;
   assign accept      = s_valid & s_ready;

   always_ff @(posedge clk_i2s) begin
      if (!reset_n) begin
         hold_q       <= '0;
         active_q     <= '0;
         hold_full    <= 1'b0;
         sr_q         <= '0;
         tx_data      <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         underrun <= 1'b0;

         if (left_start) begin
            if (hold_full) begin
               active_q  <= hold_q;
               hold_full <= 1'b0;
            end else begin
               active_q <= '0;
               underrun <= 1'b1;
               if (underrun_cnt != '1) begin
                  underrun_cnt <= underrun_cnt + {{(UNDERRUN_CNT_W-1){1'b0}}, 1'b1};
               end
            end
         end

         // a pair arriving on an empty left_start waits for the next frame
         if (accept) begin
            hold_q    <= '{l: s_data_l, r: s_data_r};
            hold_full <= 1'b1;
         end

         // output the old MSB before reloading: this is the one-slot I2S delay
         if (sclk_fall) begin
            tx_data <= sr_q[SAMPLE_W-1];
            if (left_start) begin
               sr_q <= hold_full ? hold_q.l : '0;
            end else if (right_start) begin
               sr_q <= active_q.r;
            end else begin
               sr_q <= {sr_q[SAMPLE_W-2:0], 1'b0};
            end
         end
      end
   end
endmodule
